// File: rtl/pixel_byte_streamer_pkg.sv
// Shared types and constants for the frame-dump byte streamer.
package pixel_byte_streamer_pkg;

  localparam int RGB_W = 12;

  localparam logic [7:0] SYNC_B0 = 8'hFF;
  localparam logic [7:0] SYNC_B1 = 8'h5A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_byte_streamer_fifo.sv
// Pixel FIFO whose registered head stays resident until released, so the
// entry being serialized still occupies one of the DEPTH slots.
module pixel_fifo
  import pixel_byte_streamer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [RGB_W-1:0] din,
  input  logic             pop,
  output logic [RGB_W-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int AW = $clog2(DEPTH);

  logic [RGB_W-1:0] mem [DEPTH];
  logic [RGB_W-1:0] dout_reg;
  logic             dout_valid_reg;
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      rd_ptr_next;
  logic [AW:0]      level;
  logic             do_push;
  logic             do_pop;

  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign one_left    = (level == {{AW{1'b0}}, 1'b1});
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, do_pop};

  // Read address runs one pop ahead so a released head is replaced without a bubble.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
    dout_reg <= mem[rd_ptr_next[AW-1:0]];
  end

  // An entry written this very cycle is excluded, its read would return stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
      rd_ptr_reg     <= rd_ptr_next;
      dout_valid_reg <= (wr_ptr_reg != rd_ptr_next);
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

endmodule

// File: rtl/pixel_byte_streamer.sv
// Captures one frame of active pixels and streams each as two bytes (high nibble first).
// Optional STREAM_SYNC_MARKER_EN prefixes the stream with header bytes 0xFF, 0x5A.
module pixel_byte_streamer
  import pixel_byte_streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 19
) (
  input  logic             clk,
  input  logic             hard_reset_n,
  input  logic             pix_en,
  input  logic             video_on,
  input  logic [RGB_W-1:0] rgb,
  input  logic             frame_start,
  input  logic             capture_req,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             overflow,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_count
);

  state_t           state_reg;
  logic             overflow_reg;
  logic             frame_done_reg;
  logic [CNT_W-1:0] pix_count_reg;
  logic             phase_reg;
  logic [1:0]       hdr_reg;
  logic [1:0]       hdr_next;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_one_left;
  logic             head_valid;
  logic [RGB_W-1:0] head_pix;

  logic             start_capture;
  logic             hdr_busy;
  logic             xfer;
  logic             push_ok;
  logic             drain_done;

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (hard_reset_n),
    .push       (fifo_push),
    .din        (rgb),
    .pop        (fifo_pop),
    .dout       (head_pix),
    .dout_valid (head_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .one_left   (fifo_one_left)
  );

  // A frame_start coincident with an active pixel ends the capture and drops that pixel.
  assign start_capture = (state_reg == ARM) && frame_start;
  assign fifo_push     = (state_reg == CAPTURE) && pix_en && video_on && !frame_start;
  assign hdr_busy      = (hdr_reg != 2'd0);
  assign out_valid     = hdr_busy || head_valid;
  assign xfer          = out_valid && out_ready;
  assign fifo_pop      = xfer && !hdr_busy && phase_reg;
  assign push_ok       = fifo_push && (!fifo_full || fifo_pop);
  assign drain_done    = (fifo_empty || (fifo_pop && fifo_one_left)) && (hdr_next == 2'd0);

`ifdef STREAM_SYNC_MARKER_EN
  // hdr_reg counts header bytes still to send: 2 -> SYNC_B0, 1 -> SYNC_B1.
  always_comb begin
    hdr_next = hdr_reg;
    if (start_capture) begin
      hdr_next = 2'd2;
    end else if (hdr_busy && out_ready) begin
      hdr_next = hdr_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      hdr_reg <= 2'd0;
    end else begin
      hdr_reg <= hdr_next;
    end
  end
`else
  assign hdr_next = 2'd0;
  assign hdr_reg  = 2'd0;
`endif

  always_comb begin
    out_data = 8'h00;
    if (hdr_reg == 2'd2) begin
      out_data = SYNC_B0;
    end else if (hdr_reg == 2'd1) begin
      out_data = SYNC_B1;
    end else if (head_valid) begin
      out_data = phase_reg ? head_pix[7:0] : {4'h0, head_pix[RGB_W-1:8]};
    end
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      phase_reg <= 1'b0;
    end else if (xfer && !hdr_busy) begin
      phase_reg <= ~phase_reg;
    end
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_reg      <= IDLE;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      pix_count_reg  <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (capture_req) begin
            state_reg     <= ARM;
            overflow_reg  <= 1'b0;
            pix_count_reg <= '0;
          end
        end
        ARM: begin
          if (frame_start) begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (frame_start) begin
            state_reg <= DRAIN;
          end
          if (push_ok && (pix_count_reg != '1)) begin
            pix_count_reg <= pix_count_reg + CNT_W'(1);
          end
          if (fifo_push && !push_ok) begin
            overflow_reg <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_reg      <= IDLE;
            frame_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign overflow   = overflow_reg;
  assign frame_done = frame_done_reg;
  assign pix_count  = pix_count_reg;

endmodule
